// File: rtl/uart_pkg.sv
// Shared UART definitions: interrupt identification codes and RX trigger levels.
package uart_pkg;

   typedef logic [2:0] intid_t;

   localparam intid_t INTID_LSI  = 3'b011;
   localparam intid_t INTID_RDA  = 3'b010;
   localparam intid_t INTID_CTI  = 3'b110;
   localparam intid_t INTID_THRE = 3'b001;
   localparam intid_t INTID_MSI  = 3'b000;

   localparam int unsigned TRIG_LVL_1  = 1;
   localparam int unsigned TRIG_LVL_4  = 4;
   localparam int unsigned TRIG_LVL_8  = 8;
   localparam int unsigned TRIG_LVL_14 = 14;

   // Without FIFOs the receiver holds one character, so any data is a trigger.
   function automatic int unsigned rx_trigger(input logic fifoen, input logic [1:0] sel);
      int unsigned lvl;
      lvl = TRIG_LVL_1;
      if (fifoen) begin
         case (sel)
            2'b00:   lvl = TRIG_LVL_1;
            2'b01:   lvl = TRIG_LVL_4;
            2'b10:   lvl = TRIG_LVL_8;
            default: lvl = TRIG_LVL_14;
         endcase
      end
      return lvl;
   endfunction

endpackage

// File: rtl/uart_int_ctrl_if.sv
// Signal bundle between the UART register block / FIFOs and the interrupt controller.
// Optional DMA request lines exist only when UART_INT_DMA_EN is defined.
interface uart_int_ctrl_if #(parameter int LVL_WIDTH = 5);

   logic                 erbi_in;
   logic                 etbei_in;
   logic                 elsi_in;
   logic                 edssi_in;
   logic                 fifoen_in;
   logic [1:0]           rxfiftl_in;
   logic [LVL_WIDTH-1:0] rx_level_in;
   logic                 rx_char_in;
   logic                 rx_pop_in;
   logic                 char_tick_in;
   logic                 thre_in;
   logic                 lsr_err_in;
   logic                 msr_delta_in;
   logic                 iir_rd_in;
   logic                 thr_wr_in;
   logic [2:0]           intid_out;
   logic                 ipend_out;
   logic                 irq_out;
`ifdef UART_INT_DMA_EN
   logic                 rx_dma_req_out;
   logic                 tx_dma_req_out;

   modport master (
      output erbi_in, etbei_in, elsi_in, edssi_in, fifoen_in, rxfiftl_in, rx_level_in,
             rx_char_in, rx_pop_in, char_tick_in, thre_in, lsr_err_in, msr_delta_in,
             iir_rd_in, thr_wr_in,
      input  intid_out, ipend_out, irq_out, rx_dma_req_out, tx_dma_req_out
   );

   modport slave (
      input  erbi_in, etbei_in, elsi_in, edssi_in, fifoen_in, rxfiftl_in, rx_level_in,
             rx_char_in, rx_pop_in, char_tick_in, thre_in, lsr_err_in, msr_delta_in,
             iir_rd_in, thr_wr_in,
      output intid_out, ipend_out, irq_out, rx_dma_req_out, tx_dma_req_out
   );
`else
   modport master (
      output erbi_in, etbei_in, elsi_in, edssi_in, fifoen_in, rxfiftl_in, rx_level_in,
             rx_char_in, rx_pop_in, char_tick_in, thre_in, lsr_err_in, msr_delta_in,
             iir_rd_in, thr_wr_in,
      input  intid_out, ipend_out, irq_out
   );

   modport slave (
      input  erbi_in, etbei_in, elsi_in, edssi_in, fifoen_in, rxfiftl_in, rx_level_in,
             rx_char_in, rx_pop_in, char_tick_in, thre_in, lsr_err_in, msr_delta_in,
             iir_rd_in, thr_wr_in,
      output intid_out, ipend_out, irq_out
   );
`endif

endinterface

// File: rtl/uart_rx_timeout.sv
// RX character-timeout counter: counts idle character times while the FIFO holds data
// and raises a sticky flag once TIMEOUT_CHARS have elapsed without RX activity.
module uart_rx_timeout
   import uart_pkg::*;
#(
   parameter int TIMEOUT_CHARS = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic fifoen_i,
   input  logic rx_empty_i,
   input  logic rx_char_i,
   input  logic rx_pop_i,
   input  logic char_tick_i,
   output logic timeout_o
);

   localparam int CNT_W = $clog2(TIMEOUT_CHARS + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CHARS);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             flag_q, flag_d;
   logic             clr;

   assign clr = rx_char_i | rx_pop_i | rx_empty_i | ~fifoen_i;

   // Clear beats a simultaneous tick; the count saturates at CNT_MAX.
   always_comb begin
      cnt_d  = cnt_q;
      flag_d = flag_q;
      if (clr) begin
         cnt_d  = '0;
         flag_d = 1'b0;
      end else begin
         if (char_tick_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
         end
         flag_d = (cnt_d == CNT_MAX);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q  <= '0;
         flag_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         flag_q <= flag_d;
      end
   end

   assign timeout_o = flag_q;

endmodule

// File: rtl/uart_int_ctrl.sv
// UART interrupt arbiter: gates the five sources, resolves fixed priority and registers intid/ipend/irq.
// Define UART_INT_DMA_EN to add the rx/tx DMA request outputs.
module uart_int_ctrl
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH    = 16,
   parameter int LVL_WIDTH     = 5,
   parameter int TIMEOUT_CHARS = 4
) (
   input  logic              apb_clk_in,
   input  logic              apb_rstn_in,
   uart_int_ctrl_if.slave    bus
);

   logic [LVL_WIDTH-1:0] trigger;
   int unsigned          trig_raw;
   logic                 rx_avail;
   logic                 to_flag;

   logic                 thre_prev_q, etbei_prev_q;
   logic                 thre_lat_q, thre_lat_d;
   logic                 thre_set, thre_clr;

   intid_t               intid_q, intid_d;
   logic                 ipend_q, ipend_d;
   logic                 irq_q;

   // A trigger above the FIFO depth could never be reached; clamp it.
   always_comb begin
      trig_raw = rx_trigger(bus.fifoen_in, bus.rxfiftl_in);
      if (trig_raw > FIFO_DEPTH) begin
         trig_raw = FIFO_DEPTH;
      end
      trigger = LVL_WIDTH'(trig_raw);
   end

   assign rx_avail = (bus.rx_level_in >= trigger);

   uart_rx_timeout #(
      .TIMEOUT_CHARS (TIMEOUT_CHARS)
   ) u_rx_timeout (
      .clk_i       (apb_clk_in),
      .rst_ni      (apb_rstn_in),
      .fifoen_i    (bus.fifoen_in),
      .rx_empty_i  (bus.rx_level_in == '0),
      .rx_char_i   (bus.rx_char_in),
      .rx_pop_i    (bus.rx_pop_in),
      .char_tick_i (bus.char_tick_in),
      .timeout_o   (to_flag)
   );

   // IIR read only acknowledges THRE when THRE is what the host actually saw.
   assign thre_set = (bus.thre_in & ~thre_prev_q) | (bus.etbei_in & ~etbei_prev_q & bus.thre_in);
   assign thre_clr = bus.thr_wr_in | (bus.iir_rd_in & (intid_q == INTID_THRE) & ~ipend_q);

   always_comb begin
      thre_lat_d = thre_lat_q;
      if (thre_set) begin
         thre_lat_d = 1'b1;
      end else if (thre_clr) begin
         thre_lat_d = 1'b0;
      end
   end

   always_comb begin
      intid_d = INTID_MSI;
      ipend_d = 1'b1;
      if (bus.elsi_in && bus.lsr_err_in) begin
         intid_d = INTID_LSI;
         ipend_d = 1'b0;
      end else if (bus.erbi_in && rx_avail) begin
         intid_d = INTID_RDA;
         ipend_d = 1'b0;
      end else if (bus.erbi_in && to_flag) begin
         intid_d = INTID_CTI;
         ipend_d = 1'b0;
      end else if (bus.etbei_in && thre_lat_q) begin
         intid_d = INTID_THRE;
         ipend_d = 1'b0;
      end else if (bus.edssi_in && bus.msr_delta_in) begin
         intid_d = INTID_MSI;
         ipend_d = 1'b0;
      end
   end

   always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
      if (!apb_rstn_in) begin
         thre_prev_q  <= 1'b0;
         etbei_prev_q <= 1'b0;
         thre_lat_q   <= 1'b0;
         intid_q      <= INTID_MSI;
         ipend_q      <= 1'b1;
         irq_q        <= 1'b0;
      end else begin
         thre_prev_q  <= bus.thre_in;
         etbei_prev_q <= bus.etbei_in;
         thre_lat_q   <= thre_lat_d;
         intid_q      <= intid_d;
         ipend_q      <= ipend_d;
         irq_q        <= ~ipend_d;
      end
   end

   assign bus.intid_out = intid_q;
   assign bus.ipend_out = ipend_q;
   assign bus.irq_out   = irq_q;

`ifdef UART_INT_DMA_EN
   logic rx_dma_q, tx_dma_q;

   // DMA requests follow data availability regardless of the interrupt enables.
   always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
      if (!apb_rstn_in) begin
         rx_dma_q <= 1'b0;
         tx_dma_q <= 1'b0;
      end else begin
         rx_dma_q <= (bus.fifoen_in & rx_avail) | to_flag;
         tx_dma_q <= bus.thre_in;
      end
   end

   assign bus.rx_dma_req_out = rx_dma_q;
   assign bus.tx_dma_req_out = tx_dma_q;
`endif

endmodule

// File: tb/tb_uart_int_ctrl.sv
// Bench for uart_int_ctrl: directed vectors, a cycle model of the interrupt rules and literal checkpoints.
module tb_uart_int_ctrl;

   localparam int TC = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic chk_en = 1'b0;
   int   n_tot = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   uart_int_ctrl_if #(.LVL_WIDTH(5)) bus();

   uart_int_ctrl #(
      .FIFO_DEPTH    (16),
      .LVL_WIDTH     (5),
      .TIMEOUT_CHARS (TC)
   ) dut (
      .apb_clk_in  (clk),
      .apb_rstn_in (rst_n),
      .bus         (bus)
   );

   task automatic chk(input string nm, input int act, input int exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Reference model: state after each clock edge, derived from the interrupt rules.
   int       TRIG_TAB [4] = '{1, 4, 8, 14};
   int       CODES    [5] = '{3, 2, 6, 1, 0};
   int       m_cnt   = 0;
   logic     m_flag  = 0, m_lat = 0, m_tp = 0, m_ep = 0;
   logic [2:0] m_intid = 0;
   logic     m_ipend = 1, m_rxd = 0, m_txd = 0;
   int       trig;
   logic     avail, lset, lclr, npend;
   logic [2:0] nid;
   logic     act [5];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt = 0; m_flag = 0; m_lat = 0; m_tp = 0; m_ep = 0;
         m_intid = 0; m_ipend = 1; m_rxd = 0; m_txd = 0;
      end else begin
         trig  = bus.fifoen_in ? TRIG_TAB[bus.rxfiftl_in] : 1;
         avail = int'(bus.rx_level_in) >= trig;
         act[0] = bus.elsi_in  && bus.lsr_err_in;
         act[1] = bus.erbi_in  && avail;
         act[2] = bus.erbi_in  && m_flag;
         act[3] = bus.etbei_in && m_lat;
         act[4] = bus.edssi_in && bus.msr_delta_in;
         nid = 3'd0; npend = 1'b1;
         for (int i = 0; i < 5; i++) begin
            if (act[i] && npend) begin
               nid = 3'(CODES[i]);
               npend = 1'b0;
            end
         end
         lset = (bus.thre_in && !m_tp) || (bus.etbei_in && !m_ep && bus.thre_in);
         lclr = bus.thr_wr_in || (bus.iir_rd_in && m_intid == 3'd1 && !m_ipend);
         if (lset) m_lat = 1'b1;
         else if (lclr) m_lat = 1'b0;
         m_rxd = (bus.fifoen_in && avail) || m_flag;
         m_txd = bus.thre_in;
         if (!bus.fifoen_in || bus.rx_level_in == 0 || bus.rx_char_in || bus.rx_pop_in) begin
            m_cnt = 0; m_flag = 1'b0;
         end else if (bus.char_tick_in && m_cnt < TC) begin
            m_cnt++;
            if (m_cnt == TC) m_flag = 1'b1;
         end
         m_tp = bus.thre_in;
         m_ep = bus.etbei_in;
         m_intid = nid;
         m_ipend = npend;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cyc_intid", int'(bus.intid_out), int'(m_intid));
         chk("cyc_ipend", int'(bus.ipend_out), int'(m_ipend));
         chk("cyc_irq",   int'(bus.irq_out),   int'(!m_ipend));
`ifdef UART_INT_DMA_EN
         chk("cyc_rxdma", int'(bus.rx_dma_req_out), int'(m_rxd));
         chk("cyc_txdma", int'(bus.tx_dma_req_out), int'(m_txd));
`endif
      end
   end

   initial begin
      bus.erbi_in = 1; bus.etbei_in = 1; bus.elsi_in = 1; bus.edssi_in = 1;
      bus.fifoen_in = 0; bus.rxfiftl_in = 2'b00; bus.rx_level_in = '0;
      bus.rx_char_in = 0; bus.rx_pop_in = 0; bus.char_tick_in = 0;
      bus.thre_in = 0; bus.lsr_err_in = 1; bus.msr_delta_in = 0;
      bus.iir_rd_in = 0; bus.thr_wr_in = 0;

      repeat (3) @(posedge clk);
      #2;
      chk_en = 1'b1;
      chk("rst_intid", int'(bus.intid_out), 0);
      chk("rst_ipend", int'(bus.ipend_out), 1);
      chk("rst_irq",   int'(bus.irq_out),   0);
      rst_n = 1'b1;
      step();
      chk("rel_intid", int'(bus.intid_out), 3);
      chk("rel_irq",   int'(bus.irq_out),   1);
      bus.lsr_err_in = 0; step();
      chk("lsi_drop", int'(bus.ipend_out), 1);

      // RX trigger 8
      bus.fifoen_in = 1; bus.rxfiftl_in = 2'b10; bus.rx_level_in = 5'd7; step();
      chk("lvl7_none", int'(bus.ipend_out), 1);
      bus.rx_level_in = 5'd8; step();
      chk("lvl8_rda", int'(bus.intid_out), 2);
      bus.rx_level_in = 5'd7; step();
      chk("lvl7_back", int'(bus.ipend_out), 1);

      // Character timeout
      bus.rx_level_in = 5'd3;
      for (int i = 1; i <= 4; i++) begin
         bus.char_tick_in = 1; step();
         bus.char_tick_in = 0; step();
         if (i == 3) chk("to_tick3", int'(bus.ipend_out), 1);
      end
      chk("to_cti", int'(bus.intid_out), 6);
      bus.rx_char_in = 1; step();
      bus.rx_char_in = 0; step();
      chk("to_char_clr", int'(bus.ipend_out), 1);
      for (int i = 1; i <= 3; i++) begin
         bus.char_tick_in = 1;
         if (i == 3) bus.rx_char_in = 1;
         step();
         bus.char_tick_in = 0; bus.rx_char_in = 0; step();
      end
      for (int i = 1; i <= 4; i++) begin
         bus.char_tick_in = 1; step();
         bus.char_tick_in = 0; step();
         if (i == 3) chk("to_restart3", int'(bus.ipend_out), 1);
      end
      chk("to_cti2", int'(bus.intid_out), 6);
      bus.rx_pop_in = 1; step();
      bus.rx_pop_in = 0; step();
      chk("to_pop_clr", int'(bus.ipend_out), 1);
      bus.rx_level_in = '0; step();

      // THRE latch
      bus.thre_in = 1; step(); step();
      chk("thre_set", int'(bus.intid_out), 1);
      bus.iir_rd_in = 1; step();
      bus.iir_rd_in = 0; step();
      chk("thre_iir_clr", int'(bus.ipend_out), 1);
      bus.thre_in = 0; step();
      bus.thre_in = 1; step(); step();
      chk("thre_set2", int'(bus.intid_out), 1);
      bus.thr_wr_in = 1; step();
      bus.thr_wr_in = 0; step();
      chk("thre_wr_clr", int'(bus.ipend_out), 1);
      bus.thre_in = 0; step();
      bus.thre_in = 1; step(); step();
      bus.thre_in = 0; step();
      bus.thre_in = 1; bus.iir_rd_in = 1; step();
      bus.iir_rd_in = 0; step();
      chk("thre_set_wins_id", int'(bus.intid_out), 1);
      chk("thre_set_wins_pend", int'(bus.ipend_out), 0);
      bus.thr_wr_in = 1; step();
      bus.thr_wr_in = 0; bus.etbei_in = 0; step(); step();
      chk("etbei_off", int'(bus.ipend_out), 1);
      bus.etbei_in = 1; step(); step();
      chk("etbei_edge", int'(bus.intid_out), 1);

      // Priority stack
      bus.lsr_err_in = 1; bus.rx_level_in = 5'd8; bus.msr_delta_in = 1; step();
      chk("prio_lsi", int'(bus.intid_out), 3);
      bus.lsr_err_in = 0; step();
      chk("prio_rda", int'(bus.intid_out), 2);
      bus.rx_level_in = '0; step();
      chk("prio_thre", int'(bus.intid_out), 1);
      bus.thr_wr_in = 1; step();
      bus.thr_wr_in = 0; step();
      chk("prio_msi_id", int'(bus.intid_out), 0);
      chk("prio_msi_pend", int'(bus.ipend_out), 0);
      bus.msr_delta_in = 0; step();
      chk("prio_none", int'(bus.ipend_out), 1);

      // Asynchronous reset mid-operation
      bus.lsr_err_in = 1; step();
      chk("pre_rst_lsi", int'(bus.intid_out), 3);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_pend", int'(bus.ipend_out), 1);
      chk("async_rst_irq",  int'(bus.irq_out),   0);
      step();
      rst_n = 1'b1; step();
      chk("rerel_lsi", int'(bus.intid_out), 3);
      bus.lsr_err_in = 0;
      bus.thr_wr_in = 1; step();
      bus.thr_wr_in = 0; step();

      // Enables off, RX full at trigger 14
      bus.erbi_in = 0; bus.rxfiftl_in = 2'b11; bus.rx_level_in = 5'd14; step(); step();
      chk("erbi_off_irq", int'(bus.irq_out), 0);
`ifdef UART_INT_DMA_EN
      chk("dma_rx_req", int'(bus.rx_dma_req_out), 1);
      chk("dma_tx_req", int'(bus.tx_dma_req_out), 1);
      bus.rx_level_in = 5'd13; step();
      chk("dma_rx_below", int'(bus.rx_dma_req_out), 0);
`endif
      step();
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/uart_int_ctrl.md
Name: uart_int_ctrl

Overview:
- Interrupt arbiter and scheduler for the UART.
- Collects the five UART interrupt sources, gates each with its enable bit from the register block, resolves fixed priority and drives intid/ipend back to the register block.
- Owns the RX trigger-level compare, the RX character-timeout counter and the THR-empty interrupt latch with its clear-on-read rule.
- Sits between uart_reg, the FIFOs and the baud generator.

Parameters:
FIFO_DEPTH, 16, RX FIFO depth in characters
LVL_WIDTH, 5, width of the FIFO level input; must hold FIFO_DEPTH
TIMEOUT_CHARS, 4, idle character times before a timeout interrupt

Ports:
apb_clk_in  input  1  clock
apb_rstn_in  input  1  asynchronous active-low reset
erbi_in  input  1  enable RX data / timeout interrupt
etbei_in  input  1  enable THR-empty interrupt
elsi_in  input  1  enable line-status interrupt
edssi_in  input  1  enable modem-status interrupt
fifoen_in  input  1  FIFO mode
rxfiftl_in  input  2  RX trigger select
rx_level_in  input  LVL_WIDTH  RX FIFO occupancy
rx_char_in  input  1  pulse: character written into RX FIFO
rx_pop_in  input  1  pulse: RBR read
char_tick_in  input  1  pulse: one character time elapsed
thre_in  input  1  THR/TX FIFO empty
lsr_err_in  input  1  OR of oe/pe/fe/bi
msr_delta_in  input  1  OR of dcts/ddsr/teri/dcd
iir_rd_in  input  1  pulse: IIR read
thr_wr_in  input  1  pulse: THR write
intid_out  output  3  highest-priority pending source
ipend_out  output  1  0 = interrupt pending, 1 = none
irq_out  output  1  interrupt line, high active

Behaviour:
- Reset values: intid_out=000, ipend_out=1, irq_out=0. THRE latch, timeout counter and timeout flag all clear.
- Trigger level, fifoen_in=1: rxfiftl 00/01/10/11 -> 1/4/8/14 characters. With fifoen_in=0 the trigger is 1.
- rx_avail = rx_level_in >= trigger.
- Timeout counter:
  - Active only when fifoen_in=1 and rx_level_in!=0.
  - Counts char_tick_in pulses.
  - Cleared to 0 by rx_char_in, rx_pop_in, rx_level_in==0 or fifoen_in=0.
  - Reaching TIMEOUT_CHARS sets the timeout flag and the counter saturates.
  - The flag clears under the same conditions that clear the counter.
  - A clear and a tick in the same cycle: the clear wins.
- THRE latch:
  - Set on a rising edge of thre_in, or on a rising edge of etbei_in while thre_in=1.
  - Cleared by thr_wr_in.
  - Also cleared by iir_rd_in when the registered intid_out==001 and ipend_out==0.
  - Set and clear in the same cycle: the set wins.
- Priority, highest first; each source is gated by its enable:
  - 011: elsi & lsr_err_in
  - 010: erbi & rx_avail
  - 110: erbi & timeout flag (rx_avail takes precedence)
  - 001: etbei & THRE latch
  - 000: edssi & msr_delta_in
- With no source active: intid=000, ipend=1.
- Latency: intid_out, ipend_out and irq_out are registered, one cycle after any source change. irq_out = ~ipend_out.
- Clearing of line-status and modem-status sources is owned by the status logic, not this block; they drop when their inputs drop.
- Reset asserted mid-operation: all state clears immediately and asynchronously.

Optional Feature:
- Macro UART_INT_DMA_EN.
- When defined, two outputs are added:
  - rx_dma_req_out: registered, high while fifoen_in=1 & rx_avail, or timeout flag set.
  - tx_dma_req_out: registered, high while thre_in=1.
  - Both reset to 0 and ignore the erbi/etbei enables.
- When not defined, the ports do not exist and no DMA logic is built.

Decomposition:
- Shared package uart_pkg holds:
  - intid codes INTID_LSI=3'b011, INTID_RDA=3'b010, INTID_CTI=3'b110, INTID_THRE=3'b001, INTID_MSI=3'b000.
  - Trigger-level constants.
- One sub-module, uart_rx_timeout: the timeout counter and flag, with its clear logic.

Test Plan:
- Reset, all enables=1, lsr_err_in=1 -> intid=000, ipend=1 until release; one cycle after release intid=011, irq=1.
- fifoen=1, rxfiftl=10, level stepped 7->8 with erbi=1 -> intid=010 one cycle after level=8; level 8->7 -> ipend=1.
- fifoen=1, level=3, erbi=1, four char_tick pulses with no rx_char/pop -> intid=110 after the 4th tick. Same again with an rx_char on tick 3 -> no timeout until 4 further ticks.
- etbei=1, thre rises -> intid=001. Read IIR -> ipend=1 next cycle. Repeat with a THR write instead of the IIR read -> same clear. Assert thre rising edge and IIR read together -> latch stays set.
- lsr_err, rx_avail, THRE and msr_delta all active -> intid 011. Drop them one at a time -> intid 010, 001, 000, then ipend=1.
- With UART_INT_DMA_EN defined, erbi=0, level=14, rxfiftl=11 -> rx_dma_req_out=1 and irq_out=0.
